// File: rtl/serial_deserializer.sv
// Start / WIDTH data bits (LSB first) / [odd parity] / stop deserializer with a one-word output buffer.
// Define SERIAL_DESERIALIZER_PARITY_EN to compile in the odd-parity bit and parity_err.
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             word_done;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             par_err_q, par_err_d;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        word_done   = 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
`endif

        if (bit_valid) begin
            case (state_q)
                IDLE: begin
                    if (!bit_in) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
                DATA: begin
                    shift_d = {bit_in, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
                PARITY: begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    // Odd parity: data bits plus parity bit must hold an odd number of ones.
                    par_bad_d = ~(^{shift_q, bit_in});
                    state_d   = STOP;
`else
                    state_d   = IDLE;
`endif
                end
                STOP: begin
                    state_d = IDLE;
                    if (!bit_in) begin
                        frame_err_d = 1'b1;
                    end else begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                        par_err_d = par_bad_q;
                        word_done = ~par_bad_q;
`else
                        word_done = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A same-cycle accept frees the buffer for the word completing now.
        if (word_done) begin
            if (!valid_q || out_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: all state, including the shift register and output word, is reset so nothing leaks past a reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking here so every register sees pre-edge values of the others.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed, table-driven bench for serial_deserializer (WIDTH=8), plus hand-written
// sequences for output latency/handshake and asynchronous reset mid-frame.
module tb_serial_deserializer;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         rst;
    logic         bit_in;
    logic         bit_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         frame_err;
    logic         overrun;
    logic         parity_err;

    int checks = 0;
    int errors = 0;

    serial_deserializer #(.WIDTH(W)) dut (
        .clock      (clock),
        .rst        (rst),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         do_rst;
        logic [W-1:0] data;
        logic         stop;
        int           gap;
        logic         ready;
        logic         par_flip;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_ferr;
        logic         exp_perr;
        logic         exp_ovr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One sampled bit, then `gap` idle cycles with bit_in parked at 0.
    task automatic send_bit(input logic b, input int gap);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (gap) tick();
    endtask

    // out_ready is raised only for the stop-bit cycle, when `ready` is set.
    task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap,
                              input logic ready, input logic par_flip);
        send_bit(1'b0, gap);
        for (int i = 0; i < W; i++) send_bit(d[i], gap);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        send_bit((~^d) ^ par_flip, gap);
`endif
        out_ready = ready;
        bit_in    = stop;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        bit_in    = 1'b1;
        bit_valid = 1'b0;
        out_ready = 1'b0;

        //          rst   data    stop gap rdy  pflip vld   exp     ferr perr ovr
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h81, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h55, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 3, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h0F, 1'b1, 0, 1'b1, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h96, 1'b0, 1, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0});
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
`endif

        // Asynchronous reset before any clock edge has been seen.
        rst = 1'b1;
        #2;
        check("rst_valid",    32'(out_valid),  32'h0);
        check("rst_data",     32'(data_out),   32'h0);
        check("rst_ferr",     32'(frame_err),  32'h0);
        check("rst_perr",     32'(parity_err), 32'h0);
        check("rst_overrun",  32'(overrun),    32'h0);
        tick();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) do_reset();
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, vecs[i].ready, vecs[i].par_flip);
            check($sformatf("v%0d_valid", i),   32'(out_valid),  32'(vecs[i].exp_valid));
            check($sformatf("v%0d_data", i),    32'(data_out),   32'(vecs[i].exp_data));
            check($sformatf("v%0d_ferr", i),    32'(frame_err),  32'(vecs[i].exp_ferr));
            check($sformatf("v%0d_perr", i),    32'(parity_err), 32'(vecs[i].exp_perr));
            check($sformatf("v%0d_overrun", i), 32'(overrun),    32'(vecs[i].exp_ovr));
            tick();
            check($sformatf("v%0d_ferr_pulse", i), 32'(frame_err),  32'h0);
            check($sformatf("v%0d_perr_pulse", i), 32'(parity_err), 32'h0);
        end

        // Latency: nothing visible before the stop-bit edge, word visible right after it,
        // held while out_ready=0, cleared by a single accept.
        do_reset();
        begin
            logic [W-1:0] w;
            w = 8'h5A;
            send_bit(1'b0, 0);
            for (int i = 0; i < W; i++) send_bit(w[i], 0);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            send_bit(~^w, 0);
`endif
            check("lat_pre_stop_valid", 32'(out_valid), 32'h0);
            send_bit(1'b1, 0);
            check("lat_stop_valid", 32'(out_valid), 32'h1);
            check("lat_stop_data",  32'(data_out),  32'h5A);
            repeat (3) tick();
            check("hold_valid", 32'(out_valid), 32'h1);
            check("hold_data",  32'(data_out),  32'h5A);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("accept_clears_valid", 32'(out_valid), 32'h0);
        end

        // Reset between clock edges, four data bits into a frame, with overrun already set.
        do_reset();
        send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
        check("pre_rst_overrun", 32'(overrun), 32'h1);
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid",   32'(out_valid), 32'h0);
        check("mid_rst_data",    32'(data_out),  32'h0);
        check("mid_rst_overrun", 32'(overrun),   32'h0);
        check("mid_rst_ferr",    32'(frame_err), 32'h0);
        tick();
        rst = 1'b0;
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        check("idle_ones_valid", 32'(out_valid), 32'h0);
        send_frame(8'h0F, 1'b1, 0, 1'b0, 1'b0);
        check("post_rst_valid",   32'(out_valid), 32'h1);
        check("post_rst_data",    32'(data_out),  32'h0F);
        check("post_rst_overrun", 32'(overrun),   32'h0);
        check("post_rst_ferr",    32'(frame_err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
SERIAL_DESERIALIZER -- requirements
Module: serial_deserializer

Interface
REQ-001 Parameter: WIDTH, 8, number of data bits per frame (2..16).
REQ-002 Port: clock  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: bit_in  input  1  serial bit from the upstream flip-flop stage.
REQ-005 Port: bit_valid  input  1  bit_in is sampled only in cycles where this is 1.
REQ-006 Port: data_out  output  WIDTH  assembled word, valid while out_valid=1.
REQ-007 Port: out_valid  output  1  word available.
REQ-008 Port: out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
REQ-009 Port: frame_err  output  1  one-cycle pulse when the stop bit sampled is 0.
REQ-010 Port: overrun  output  1  sticky flag for a completed word lost because out_valid was still 1.
REQ-011 Port: parity_err  output  1  one-cycle pulse on an odd-parity mismatch (0 when the macro is absent).

Function
REQ-012 FSM states SHALL be IDLE, DATA, PARITY, STOP; the state changes only in cycles with bit_valid=1.
REQ-013 In IDLE, a sampled 0 (start bit) SHALL go to DATA with bit count 0; a sampled 1 SHALL stay in IDLE.
REQ-014 In DATA, each sampled bit SHALL shift in LSB-first; after the WIDTH-th bit, the next state SHALL be PARITY if the macro is defined, else STOP.
REQ-015 The bit counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL clear on entering DATA.
REQ-016 In PARITY, the sampled bit SHALL be compared with odd parity over the WIDTH data bits, and the FSM SHALL then go to STOP.
REQ-017 In STOP, a sampled 1 with no parity error SHALL complete the word.
REQ-018 A sampled 0 in STOP SHALL pulse frame_err for 1 cycle and discard the word; a parity mismatch SHALL pulse parity_err and discard the word; both SHALL return to IDLE.
REQ-019 Completion SHALL load data_out and set out_valid in the cycle after the stop-bit sample edge (latency: 1 clock after the stop-bit edge).
REQ-020 out_valid SHALL clear on the edge where out_valid=1 and out_ready=1; data_out SHALL hold until then.
REQ-021 If a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, data_out SHALL be unchanged, and overrun SHALL set.
REQ-022 If a word completes in the same cycle out_ready=1 accepts the old word, the new word SHALL load, out_valid SHALL stay 1, and no overrun SHALL be flagged.
REQ-023 overrun SHALL clear only on reset.
REQ-024 Cycles with bit_valid=0 SHALL leave the FSM, shift register and counter unchanged.

Reset
REQ-025 rst=1 SHALL immediately (no clock) force IDLE, counter 0, shift register 0, data_out 0, out_valid 0, frame_err 0, parity_err 0, overrun 0.
REQ-026 A reset mid-frame SHALL discard the partial word; after release, the first sampled 0 starts a new frame.

Configuration
REQ-027 Macro SERIAL_DESERIALIZER_PARITY_EN: when defined, the PARITY state and parity_err logic SHALL be compiled in.
REQ-028 When SERIAL_DESERIALIZER_PARITY_EN is undefined, the frame SHALL be start+WIDTH+stop, PARITY SHALL never be entered, and parity_err SHALL be tied 0.

Verification
REQ-029 Without macro, bits 0,1,0,1,0,0,1,0,1,1 with bit_valid=1 and out_ready=0 -> data_out=8'hA5 and out_valid=1 one clock after the stop-bit edge.
REQ-030 Same frame with the stop bit 0 -> frame_err high 1 cycle, out_valid stays 0, FSM returns to IDLE.
REQ-031 Two 8'h3C frames back-to-back with out_ready=0 -> data_out=8'h3C, overrun=1; repeat with out_ready=1 on the completion cycle -> overrun=0.
REQ-032 bit_valid=0 for 3 cycles between every bit of an 8'hA5 frame -> result identical to REQ-029.
REQ-033 rst pulsed between clock edges after 4 data bits -> all outputs 0 immediately; a following 8'h0F frame is received correctly.
REQ-034 With the macro, 8'hA5 (four ones) sent with parity bit 1 -> data_out=8'hA5; sent with parity bit 0 -> parity_err pulse and no out_valid.
